// File: rtl/gshare_ctrl.sv
// gshare_ctrl: sequencer for the 2-bit-counter global predictor table.
// Owns the global history register, forms the gshare read index, keeps an
// in-order queue of in-flight conditional branches, issues one table update
// per resolved branch, repairs history on mispredict and sweeps the table to
// weakly-taken after reset.
module gshare_ctrl #(
  parameter int HIST_BITS = 12,
  parameter int DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_valid,
  input  logic [31:0]          fetch_pc,
  input  logic [31:0]          fetch_inst,
  output logic                 fetch_ready,
  output logic [HIST_BITS-1:0] tbl_rd_idx,
  input  logic                 tbl_rd_taken,
  output logic                 pred_taken,
  input  logic                 resolve_valid,
  input  logic                 resolve_taken,
  output logic                 mispredict,
  output logic                 tbl_we,
  output logic [HIST_BITS-1:0] tbl_widx,
  output logic                 tbl_wtaken,
  output logic                 tbl_winit,
  output logic                 busy,
  output logic                 resolve_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [HIST_BITS-1:0] ptr_q, ptr_d;
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [AW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;

  // Queue storage; the snapshot drops the history MSB since repair shifts it out.
  logic [HIST_BITS-1:0] q_idx_q [DEPTH];
  logic [HIST_BITS-1:0] q_idx_d [DEPTH];
  logic [HIST_BITS-2:0] q_ghr_q [DEPTH];
  logic [HIST_BITS-2:0] q_ghr_d [DEPTH];
  logic [DEPTH-1:0]     q_pred_q, q_pred_d;

  logic                 upd_we_q, upd_we_d;
  logic [HIST_BITS-1:0] upd_idx_q, upd_idx_d;
  logic                 upd_taken_q, upd_taken_d;
  logic                 mispredict_q, mispredict_d;
  logic                 resolve_err_q, resolve_err_d;

  logic                 run;
  logic                 is_branch;
  logic                 pred_c;
  logic [HIST_BITS-1:0] rd_idx_c;
  logic                 pop;
  logic                 mispredict_cond;
  logic                 ready_c;
  logic                 accept;

  // PC and instruction bits outside the index slice and opcode are not needed.
  logic unused_bits;
  assign unused_bits = ^{fetch_pc[31:HIST_BITS+2], fetch_pc[1:0], fetch_inst[31:7]};

  // Decode of the current cycle: prediction, index, pop and accept handshakes.
  always_comb begin
    run             = (state_q == S_RUN);
    is_branch       = (fetch_inst[6:0] == 7'b1100011);
    pred_c          = run & tbl_rd_taken;
    rd_idx_c        = fetch_pc[HIST_BITS+1:2] ^ ghr_q;
    pop             = run && resolve_valid && (count_q != '0);
    mispredict_cond = pop && (resolve_taken != q_pred_q[head_q]);
    // A pop frees a slot in the same cycle, so a full queue may still accept.
    ready_c         = run && ((count_q < CW'(DEPTH)) || pop) && !mispredict_cond;
    accept          = fetch_valid && is_branch && ready_c;
  end

  // Next-state logic: INIT sweeps every entry once, then RUN until reset.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + HIST_BITS'(1);
        if (ptr_q == {HIST_BITS{1'b1}}) state_d = S_RUN;
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // Queue push/pop, speculative history shift and mispredict flush/repair.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    ghr_d    = ghr_q;
    q_idx_d  = q_idx_q;
    q_ghr_d  = q_ghr_q;
    q_pred_d = q_pred_q;
    if (mispredict_cond) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ghr_d   = {q_ghr_q[head_q], resolve_taken};
    end else begin
      if (accept) begin
        q_idx_d[tail_q]  = rd_idx_c;
        q_ghr_d[tail_q]  = ghr_q[HIST_BITS-2:0];
        q_pred_d[tail_q] = pred_c;
        tail_d           = tail_q + AW'(1);
        ghr_d            = {ghr_q[HIST_BITS-2:0], pred_c};
      end
      if (pop) head_d = head_q + AW'(1);
      count_d = count_q + CW'(accept) - CW'(pop);
    end
  end

  // Registered table update, mispredict pulse and sticky empty-resolve flag.
  always_comb begin
    upd_we_d      = pop;
    upd_idx_d     = q_idx_q[head_q];
    upd_taken_d   = resolve_taken;
    mispredict_d  = mispredict_cond;
    resolve_err_d = resolve_err_q | (resolve_valid & ~pop);
  end

  // Control and output state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      ptr_q         <= '0;
      ghr_q         <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      upd_we_q      <= 1'b0;
      upd_idx_q     <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      resolve_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      ghr_q         <= ghr_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      upd_we_q      <= upd_we_d;
      upd_idx_q     <= upd_idx_d;
      upd_taken_q   <= upd_taken_d;
      mispredict_q  <= mispredict_d;
      resolve_err_q <= resolve_err_d;
    end
  end

  // Queue payload storage; validity is tracked by the pointers, so no reset.
  always_ff @(posedge clk) begin
    q_idx_q  <= q_idx_d;
    q_ghr_q  <= q_ghr_d;
    q_pred_q <= q_pred_d;
  end

  assign fetch_ready = ready_c;
  assign tbl_rd_idx  = rd_idx_c;
  assign pred_taken  = pred_c;
  assign mispredict  = mispredict_q;
  assign busy        = !run;
  assign tbl_winit   = !run;
  assign tbl_we      = !run | upd_we_q;
  assign tbl_widx    = run ? upd_idx_q : ptr_q;
  assign tbl_wtaken  = run & upd_taken_q;
  assign resolve_err = resolve_err_q;

endmodule

// File: tb/tb_gshare_ctrl.sv
// Directed testbench for gshare_ctrl with hand-computed expectations.
module tb_gshare_ctrl;

  localparam logic [31:0] BEQ = 32'h0000_0063;
  localparam logic [31:0] ADD = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_inst = '0;
  logic        fetch_ready;
  logic [11:0] tbl_rd_idx;
  logic        tbl_rd_taken = 1'b0;
  logic        pred_taken;
  logic        resolve_valid = 1'b0;
  logic        resolve_taken = 1'b0;
  logic        mispredict;
  logic        tbl_we;
  logic [11:0] tbl_widx;
  logic        tbl_wtaken;
  logic        tbl_winit;
  logic        busy;
  logic        resolve_err;

  int errors = 0;
  int checks = 0;

  gshare_ctrl #(.HIST_BITS(12), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
    .fetch_ready(fetch_ready), .tbl_rd_idx(tbl_rd_idx), .tbl_rd_taken(tbl_rd_taken),
    .pred_taken(pred_taken), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .mispredict(mispredict), .tbl_we(tbl_we), .tbl_widx(tbl_widx),
    .tbl_wtaken(tbl_wtaken), .tbl_winit(tbl_winit), .busy(busy), .resolve_err(resolve_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, let combinational outputs settle.
  task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                     input logic rdt, input logic rv, input logic rt);
    @(negedge clk);
    fetch_valid   = fv;
    fetch_pc      = pc;
    fetch_inst    = inst;
    tbl_rd_taken  = rdt;
    resolve_valid = rv;
    resolve_taken = rt;
    #1;
  endtask

  logic [11:0] fill_idx [7];
  logic [11:0] abc;
  logic [11:0] g;
  logic        b;
  logic        prev;
  int          bad;

  initial begin
    fill_idx = '{12'h001, 12'h003, 12'h007, 12'h00F, 12'h01F, 12'h03F, 12'h07F};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cyc(1'b0, 32'h40, BEQ, 1'b1, 1'b0, 1'b0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_fetch_ready", fetch_ready, 0);
    check_eq("rst_pred_gated", pred_taken, 0);
    check_eq("rst_mispredict", mispredict, 0);
    check_eq("rst_resolve_err", resolve_err, 0);
    check_eq("rst_widx", tbl_widx, 0);

    // Partial sweep with a resolve during INIT, then reset at cycle 100
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k <= 100; k++) begin
      if (tbl_we !== 1'b1 || tbl_winit !== 1'b1 || tbl_widx !== 12'(k) || busy !== 1'b1)
        bad++;
      if (k == 51) check_eq("init_resolve_err", resolve_err, 1);
      resolve_valid = (k == 50);
      if (k < 100) @(negedge clk);
    end
    check_eq("sweep1_bad_cycles", bad, 0);
    resolve_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("restart_widx", tbl_widx, 0);
    check_eq("restart_busy", busy, 1);
    check_eq("restart_clears_err", resolve_err, 0);
    rst_n = 1'b1;

    // Full sweep: 4096 INIT cycles
    bad = 0;
    for (int k = 0; k < 4096; k++) begin
      if (tbl_we !== 1'b1 || tbl_winit !== 1'b1 || tbl_widx !== 12'(k) ||
          busy !== 1'b1 || fetch_ready !== 1'b0)
        bad++;
      @(negedge clk);
    end
    check_eq("sweep2_bad_cycles", bad, 0);
    check_eq("run_busy", busy, 0);
    check_eq("run_fetch_ready", fetch_ready, 1);
    check_eq("run_tbl_we", tbl_we, 0);
    check_eq("run_tbl_winit", tbl_winit, 0);

    // First branch: pc=0x40, ghr=0
    cyc(1'b1, 32'h40, BEQ, 1'b1, 1'b0, 1'b0);
    check_eq("a_rd_idx", tbl_rd_idx, 12'h010);
    check_eq("a_pred", pred_taken, 1);
    check_eq("a_ready", fetch_ready, 1);
    cyc(1'b0, 32'h40, BEQ, 1'b1, 1'b0, 1'b0);
    check_eq("a_ghr_shift", tbl_rd_idx, 12'h011);
    check_eq("a_no_write", tbl_we, 0);

    // Fill the queue to 8 entries
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 32'h0, BEQ, 1'b1, 1'b0, 1'b0);
      check_eq("fill_idx", tbl_rd_idx, fill_idx[i]);
      check_eq("fill_ready", fetch_ready, 1);
    end
    cyc(1'b1, 32'h0, BEQ, 1'b1, 1'b0, 1'b0);
    check_eq("full_ready", fetch_ready, 0);
    check_eq("full_idx", tbl_rd_idx, 12'h0FF);
    cyc(1'b1, 32'h0, BEQ, 1'b1, 1'b0, 1'b0);
    check_eq("full_held_idx", tbl_rd_idx, 12'h0FF);

    // Correct resolve plus fetch on a full queue
    cyc(1'b1, 32'h0, BEQ, 1'b0, 1'b1, 1'b1);
    check_eq("pop_push_ready", fetch_ready, 1);
    check_eq("pop_push_pred", pred_taken, 0);
    cyc(1'b0, 32'h0, BEQ, 1'b0, 1'b0, 1'b0);
    check_eq("upd_we", tbl_we, 1);
    check_eq("upd_winit", tbl_winit, 0);
    check_eq("upd_widx", tbl_widx, 12'h010);
    check_eq("upd_wtaken", tbl_wtaken, 1);
    check_eq("upd_no_mispredict", mispredict, 0);
    check_eq("pop_push_ghr", tbl_rd_idx, 12'h1FE);
    check_eq("count_still_full", fetch_ready, 0);

    // Mispredict on head (idx 0x001, snapshot 0x001, pred 1)
    cyc(1'b1, 32'h0, BEQ, 1'b1, 1'b1, 1'b0);
    check_eq("mp1_same_cycle_ready", fetch_ready, 0);
    cyc(1'b0, 32'h0, BEQ, 1'b0, 1'b0, 1'b0);
    check_eq("mp1_pulse", mispredict, 1);
    check_eq("mp1_we", tbl_we, 1);
    check_eq("mp1_widx", tbl_widx, 12'h001);
    check_eq("mp1_wtaken", tbl_wtaken, 0);
    check_eq("mp1_ghr_repair", tbl_rd_idx, 12'h002);
    check_eq("mp1_flushed_ready", fetch_ready, 1);
    cyc(1'b0, 32'h0, BEQ, 1'b0, 1'b0, 1'b0);
    check_eq("mp1_pulse_end", mispredict, 0);
    check_eq("mp1_we_end", tbl_we, 0);

    // Steer history to 0xABC with back-to-back push and correct resolve
    abc  = 12'hABC;
    g    = 12'h002;
    prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b = abc[11-i];
      cyc(1'b1, 32'h0, BEQ, b, (i > 0), prev);
      check_eq("abc_idx", tbl_rd_idx, g);
      check_eq("abc_ready", fetch_ready, 1);
      g    = {g[10:0], b};
      prev = b;
    end
    cyc(1'b1, 32'h40, BEQ, 1'b1, 1'b1, prev);
    check_eq("abc_last_idx", tbl_rd_idx, 12'hAAC);
    cyc(1'b0, 32'h0, BEQ, 1'b0, 1'b1, 1'b0);
    check_eq("mp2_same_cycle_ready", fetch_ready, 0);
    cyc(1'b0, 32'h0, BEQ, 1'b0, 1'b0, 1'b0);
    check_eq("mp2_pulse", mispredict, 1);
    check_eq("mp2_we", tbl_we, 1);
    check_eq("mp2_widx", tbl_widx, 12'hAAC);
    check_eq("mp2_wtaken", tbl_wtaken, 0);
    check_eq("mp2_ghr_repair", tbl_rd_idx, 12'h578);
    check_eq("mp2_flushed_ready", fetch_ready, 1);
    cyc(1'b0, 32'h0, BEQ, 1'b0, 1'b0, 1'b0);
    check_eq("mp2_pulse_end", mispredict, 0);

    // Resolve with an empty queue
    cyc(1'b0, 32'h0, BEQ, 1'b0, 1'b1, 1'b1);
    check_eq("empty_err_before", resolve_err, 0);
    cyc(1'b0, 32'h0, BEQ, 1'b0, 1'b0, 1'b0);
    check_eq("empty_no_write", tbl_we, 0);
    check_eq("empty_err_set", resolve_err, 1);
    check_eq("empty_ghr_same", tbl_rd_idx, 12'h578);
    check_eq("empty_no_mispredict", mispredict, 0);
    repeat (3) cyc(1'b0, 32'h0, BEQ, 1'b0, 1'b0, 1'b0);
    check_eq("err_sticky", resolve_err, 1);

    // Non-branch must not enqueue or shift history
    cyc(1'b1, 32'h40, ADD, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h80, BEQ, 1'b0, 1'b0, 1'b0);
    check_eq("nb_ghr_unchanged", tbl_rd_idx, 12'h558);
    cyc(1'b0, 32'h0, BEQ, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, BEQ, 1'b0, 1'b0, 1'b0);
    check_eq("nb_head_we", tbl_we, 1);
    check_eq("nb_head_widx", tbl_widx, 12'h558);
    check_eq("nb_no_mispredict", mispredict, 0);
    check_eq("nb_ghr_after", tbl_rd_idx, 12'hAF0);

    // Reset clears the sticky error and restarts INIT
    rst_n = 1'b0;
    cyc(1'b0, 32'h0, BEQ, 1'b0, 1'b0, 1'b0);
    check_eq("final_rst_err", resolve_err, 0);
    check_eq("final_rst_busy", busy, 1);
    check_eq("final_rst_ready", fetch_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
